// File: rtl/reg_file_64_pkg.sv
// Shared constants for the 64-bit, 32-entry register file with a hardwired zero register.
package reg_file_64_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int REG_CNT    = 32;
  localparam int ADDR_W     = 5;
  localparam int XZR_IDX    = 31;

  localparam logic [ADDR_W-1:0] XZR_ADDR = ADDR_W'(XZR_IDX);

endpackage

// File: rtl/reg_file_64_decoder.sv
// Write-back select decoder: turns a 5-bit register index into a gated one-hot enable vector.
module wb_decoder5_32
  import reg_file_64_pkg::*;
(
  input  logic              en,
  input  logic [ADDR_W-1:0] sel,
  output logic [REG_CNT-1:0] onehot
);

  // NOTE: assigning a default at the top of always_comb guarantees no latch is inferred.
  always_comb begin
    onehot = '0;
    // sel is only looked at when en is high, so an unknown index with en low stays harmless.
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/reg_file_64.sv
// Register file: 31 writable registers plus XZR, one write-back port, two combinational
// read ports with optional same-cycle write forwarding.
module reg_file_64
  import reg_file_64_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  logic [REG_CNT-1:0] wr_onehot;
  logic [DATA_W-1:0]  regs_q [XZR_IDX];
  logic [DATA_W-1:0]  regs_d [XZR_IDX];
  logic               unused_xzr_sel;

  wb_decoder5_32 u_wb_decoder (
    .en     (RegWrite),
    .sel    (WriteReg),
    .onehot (wr_onehot)
  );

  // The XZR enable line exists in the decoder but has no storage behind it.
  assign unused_xzr_sel = wr_onehot[XZR_IDX];

  always_comb begin
    for (int i = 0; i < XZR_IDX; i++) begin
      regs_d[i] = wr_onehot[i] ? WriteData : regs_q[i];
    end
  end

  // NOTE: this array is built from resettable flops, not a RAM macro, because every
  // register must clear asynchronously; sequential state is assigned with <= only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < XZR_IDX; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < XZR_IDX; i++) regs_q[i] <= regs_d[i];
    end
  end

  // XZR and reset both force zero; forwarding never applies to index 31.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] val;
    val = '0;
    if (!rst && idx != XZR_ADDR) begin
      if (BYPASS != 0 && RegWrite && WriteReg == idx) val = WriteData;
      else                                            val = regs_q[idx];
    end
    return val;
  endfunction

  always_comb begin
    ReadData1 = read_port(ReadReg1);
    ReadData2 = read_port(ReadReg2);
  end

endmodule

// File: tb/tb_reg_file_64.sv
// Directed bench for reg_file_64: a forwarding instance and a non-forwarding instance
// share all inputs and are compared against hand-computed values.
module tb_reg_file_64;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [63:0] WriteData;
  logic [4:0]  ReadReg1, ReadReg2;
  logic [63:0] ReadData1, ReadData2;
  logic [63:0] nb_ReadData1, nb_ReadData2;

  logic [63:0] model [32];
  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  reg_file_64 #(.DATA_W(64), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(ReadData1), .ReadData2(ReadData2)
  );

  reg_file_64 #(.DATA_W(64), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(nb_ReadData1), .ReadData2(nb_ReadData2)
  );

  task automatic do_write(input logic [4:0] idx, input logic [63:0] d);
    @(negedge clk);
    RegWrite = 1'b1; WriteReg = idx; WriteData = d;
    @(posedge clk); #1;
    RegWrite = 1'b0;
    if (idx != 5'd31 && !rst) model[idx] = d;
  endtask

  // Reads every index on both ports of both instances and compares against the model.
  task automatic read_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i);
      #1;
      total_cnt++;
      if (ReadData1 !== model[i] || nb_ReadData1 !== model[i])
        $display("FAIL %s rd1[%0d]: got %h/%h exp %h", tag, i, ReadData1, nb_ReadData1, model[i]);
      else pass_cnt++;
      total_cnt++;
      if (ReadData2 !== model[31-i] || nb_ReadData2 !== model[31-i])
        $display("FAIL %s rd2[%0d]: got %h/%h exp %h", tag, 31 - i, ReadData2, nb_ReadData2, model[31-i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    do_write(5'd5, 64'h1234);
    ReadReg1 = 5'd5; #1;
    total_cnt++;
    if (ReadData1 !== 64'h1234) $display("FAIL preload_x5: got %h exp %h", ReadData1, 64'h1234);
    else pass_cnt++;
    // Mid-cycle assertion must clear X5 before any further clock edge.
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (ReadData1 !== 64'h0 || nb_ReadData1 !== 64'h0)
      $display("FAIL async_clear_x5: got %h/%h exp 0", ReadData1, nb_ReadData1);
    else pass_cnt++;
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
    // Bypass must be suppressed while reset is held.
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 64'h55; ReadReg2 = 5'd5;
    #1;
    total_cnt++;
    if (ReadData2 !== 64'h0) $display("FAIL bypass_in_reset: got %h exp 0", ReadData2);
    else pass_cnt++;
    RegWrite = 1'b0;
    read_all("reset_sweep");
    // Write presented on the deassertion edge is dropped.
    @(negedge clk);
    RegWrite = 1'b1; WriteReg = 5'd6; WriteData = 64'h77;
    @(posedge clk); #1;
    rst = 1'b0; RegWrite = 1'b0; ReadReg1 = 5'd6;
    #1;
    total_cnt++;
    if (ReadData1 !== 64'h0) $display("FAIL deassert_edge_write: got %h exp 0", ReadData1);
    else pass_cnt++;
    do_write(5'd6, 64'h77);
    total_cnt++;
    if (ReadData1 !== 64'h77) $display("FAIL first_write_after_reset: got %h exp 77", ReadData1);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    do_write(5'd3, 64'hDEADBEEF_00000001);
    do_write(5'd30, 64'hFFFF_FFFF_FFFF_FFFF);
    ReadReg1 = 5'd3; ReadReg2 = 5'd30; #1;
    total_cnt++;
    if (ReadData1 !== 64'hDEADBEEF_00000001 || nb_ReadData1 !== 64'hDEADBEEF_00000001)
      $display("FAIL read_x3: got %h/%h exp deadbeef00000001", ReadData1, nb_ReadData1);
    else pass_cnt++;
    total_cnt++;
    if (ReadData2 !== 64'hFFFF_FFFF_FFFF_FFFF || nb_ReadData2 !== 64'hFFFF_FFFF_FFFF_FFFF)
      $display("FAIL read_x30: got %h/%h exp ffffffffffffffff", ReadData2, nb_ReadData2);
    else pass_cnt++;
  endtask

  task automatic test_xzr();
    @(negedge clk);
    ReadReg1 = 5'd31; ReadReg2 = 5'd3;
    RegWrite = 1'b1; WriteReg = 5'd31; WriteData = 64'hAAAA;
    #1;
    total_cnt++;
    if (ReadData1 !== 64'h0 || nb_ReadData1 !== 64'h0)
      $display("FAIL xzr_before_edge: got %h/%h exp 0", ReadData1, nb_ReadData1);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (ReadData1 !== 64'h0 || nb_ReadData1 !== 64'h0)
      $display("FAIL xzr_after_edge: got %h/%h exp 0", ReadData1, nb_ReadData1);
    else pass_cnt++;
    RegWrite = 1'b0;
    #1;
    total_cnt++;
    if (ReadData2 !== 64'hDEADBEEF_00000001)
      $display("FAIL xzr_no_side_effect: got %h exp deadbeef00000001", ReadData2);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    do_write(5'd7, 64'h10);
    @(negedge clk);
    RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 64'h20;
    ReadReg1 = 5'd7; ReadReg2 = 5'd7;
    #1;
    total_cnt++;
    if (ReadData1 !== 64'h20 || ReadData2 !== 64'h20)
      $display("FAIL bypass_on: got %h/%h exp 20", ReadData1, ReadData2);
    else pass_cnt++;
    total_cnt++;
    if (nb_ReadData1 !== 64'h10 || nb_ReadData2 !== 64'h10)
      $display("FAIL bypass_off_pre: got %h/%h exp 10", nb_ReadData1, nb_ReadData2);
    else pass_cnt++;
    @(posedge clk); #1;
    RegWrite = 1'b0;
    model[7] = 64'h20;
    #1;
    total_cnt++;
    if (nb_ReadData1 !== 64'h20 || nb_ReadData2 !== 64'h20)
      $display("FAIL bypass_off_post: got %h/%h exp 20", nb_ReadData1, nb_ReadData2);
    else pass_cnt++;
  endtask

  task automatic test_write_gating();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      RegWrite = 1'b0; WriteReg = 5'(i); WriteData = {$urandom, $urandom};
    end
    @(negedge clk);
    read_all("gated_sweep");
    for (int i = 0; i < 31; i++) do_write(5'(i), 64'(i) * 64'h0101);
    read_all("indexed_sweep");
  endtask

  task automatic test_reset_mid_sequence();
    for (int i = 0; i < 10; i++) do_write(5'(i), 64'hF0F0_0000 | 64'(i));
    @(negedge clk); #2;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
    @(negedge clk);
    RegWrite = 1'b1; WriteReg = 5'd10; WriteData = 64'hF0F0_000A;
    @(posedge clk); #1;
    rst = 1'b0; RegWrite = 1'b0;
    read_all("mid_reset_sweep");
    do_write(5'd10, 64'hF0F0_000A);
    ReadReg1 = 5'd10; ReadReg2 = 5'd9; #1;
    total_cnt++;
    if (ReadData1 !== 64'hF0F0_000A || ReadData2 !== 64'h0)
      $display("FAIL post_reset_write: got %h/%h exp f0f0000a/0", ReadData1, ReadData2);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadReg1 = '0; ReadReg2 = '0;
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
    #12;
    rst = 1'b0;
    test_reset();
    test_write_read();
    test_xzr();
    test_bypass();
    test_write_gating();
    test_reset_mid_sequence();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
